// File: rtl/mips_multicycle_controller.sv
// mips_multicycle_controller
//
// Purpose:
//   Moore control FSM for the multicycle MIPS datapath built around one shared
//   memory, one ULA and the IR/A/B/ULAout/Data holding registers. Each
//   instruction is sequenced over 2-5 cycles. The FSM also keeps a count of
//   retired instructions.
//
// Ports:
//   clk, reset          : clock and synchronous active-high reset
//   op, funct           : IR[31:26] and IR[5:0], held stable by the IR
//   zero                : ULA zero flag, only used for the beq PC enable
//   iord .. regwrite    : memory / IR / register-file selects and enables
//   ULAsrca, ULAsrcb    : ULA operand selects
//   ULAcontrol          : ULA operation (010 add, 110 sub, 000 and, 001 or, 111 slt)
//   pcsrc, pcen         : PC source select and PC load enable
//   state               : current state code, for debug
//   retired             : completed-instruction counter, wraps modulo 2^CNT_W
module mips_multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             iord,
    output logic             memread,
    output logic             memwrite,
    output logic             irwrite,
    output logic             regdst,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             ULAsrca,
    output logic [1:0]       ULAsrcb,
    output logic [2:0]       ULAcontrol,
    output logic [1:0]       pcsrc,
    output logic             pcen,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11
    } state_t;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_RTYP = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [2:0] ULA_ADD = 3'b010;
    localparam logic [2:0] ULA_SUB = 3'b110;

    typedef struct packed {
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       ulasrca;
        logic [1:0] ulasrcb;
        logic [2:0] ulacontrol;
        logic [1:0] pcsrc;
        logic       pcwrite;
        logic       branch;
    } ctrl_t;

    state_t     cur_state;
    state_t     next_state;
    state_t     target_state;
    ctrl_t      ctrl_d;
    ctrl_t      ctrl_q;
    logic [CNT_W-1:0] retired_q;

    // R-type operation decode; unknown funct codes fall back to add.
    function automatic logic [2:0] funct_decode(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Next-state logic. Unsupported opcodes and illegal codes return to FETCH.
    always_comb begin
        next_state = FETCH;
        case (cur_state)
            FETCH:   next_state = DECODE;
            DECODE: begin
                case (op)
                    OP_LW, OP_SW: next_state = MEMADR;
                    OP_RTYP:      next_state = RTYPEEX;
                    OP_BEQ:       next_state = BEQEX;
                    OP_ADDI:      next_state = ADDIEX;
                    OP_J:         next_state = JEX;
                    default:      next_state = FETCH;
                endcase
            end
            MEMADR:  next_state = (op == OP_LW) ? MEMRD : MEMWR;
            MEMRD:   next_state = MEMWB;
            RTYPEEX: next_state = RTYPEWB;
            ADDIEX:  next_state = ADDIWB;
            default: next_state = FETCH;
        endcase
    end

    // Output decode for the state about to be entered, so the Moore outputs
    // come straight from flops. The R-type ULA operation is decoded from funct
    // on the DECODE->RTYPEEX edge; the IR already holds it at that point.
    always_comb begin
        target_state = reset ? FETCH : next_state;
        ctrl_d = '0;
        ctrl_d.ulacontrol = ULA_ADD;
        case (target_state)
            FETCH: begin
                ctrl_d.memread = 1'b1;
                ctrl_d.irwrite = 1'b1;
                ctrl_d.pcwrite = 1'b1;
                ctrl_d.ulasrcb = 2'b01;
            end
            DECODE:  ctrl_d.ulasrcb = 2'b11;
            MEMADR, ADDIEX: begin
                ctrl_d.ulasrca = 1'b1;
                ctrl_d.ulasrcb = 2'b10;
            end
            MEMRD: begin
                ctrl_d.iord    = 1'b1;
                ctrl_d.memread = 1'b1;
            end
            MEMWB: begin
                ctrl_d.memtoreg = 1'b1;
                ctrl_d.regwrite = 1'b1;
            end
            MEMWR: begin
                ctrl_d.iord     = 1'b1;
                ctrl_d.memwrite = 1'b1;
            end
            RTYPEEX: begin
                ctrl_d.ulasrca    = 1'b1;
                ctrl_d.ulacontrol = funct_decode(funct);
            end
            RTYPEWB: begin
                ctrl_d.regdst   = 1'b1;
                ctrl_d.regwrite = 1'b1;
            end
            BEQEX: begin
                ctrl_d.ulasrca    = 1'b1;
                ctrl_d.ulacontrol = ULA_SUB;
                ctrl_d.pcsrc      = 2'b01;
                ctrl_d.branch     = 1'b1;
            end
            ADDIWB:  ctrl_d.regwrite = 1'b1;
            JEX: begin
                ctrl_d.pcsrc   = 2'b10;
                ctrl_d.pcwrite = 1'b1;
            end
            default: ctrl_d = ctrl_d;
        endcase
    end

    // State, registered outputs and the retired counter. An instruction retires
    // on any edge that re-enters FETCH from another state, including the NOP
    // path out of DECODE; the reset edge never counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_state <= FETCH;
            retired_q <= '0;
        end else begin
            cur_state <= next_state;
            if (next_state == FETCH && cur_state != FETCH)
                retired_q <= retired_q + CNT_W'(1);
        end
        ctrl_q <= ctrl_d;
    end

    // While reset is high the side-effecting enables are held off; zero reaches
    // pcen combinationally so a branch resolves in BEQEX itself.
    assign iord       = ctrl_q.iord;
    assign memread    = ctrl_q.memread  & ~reset;
    assign memwrite   = ctrl_q.memwrite & ~reset;
    assign irwrite    = ctrl_q.irwrite  & ~reset;
    assign regdst     = ctrl_q.regdst;
    assign memtoreg   = ctrl_q.memtoreg;
    assign regwrite   = ctrl_q.regwrite & ~reset;
    assign ULAsrca    = ctrl_q.ulasrca;
    assign ULAsrcb    = ctrl_q.ulasrcb;
    assign ULAcontrol = ctrl_q.ulacontrol;
    assign pcsrc      = ctrl_q.pcsrc;
    assign pcen       = (ctrl_q.pcwrite | (ctrl_q.branch & zero)) & ~reset;
    assign state      = cur_state;
    assign retired    = retired_q;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// tb_mips_multicycle_controller
//
// Purpose:
//   Self-checking bench for mips_multicycle_controller. Expected behaviour comes
//   from an instruction-level model: each opcode maps to its list of visited
//   states, each state to its table of control outputs, and the retired count
//   is bumped once per completed instruction.
//
// Ports: none (top-level bench).
module tb_mips_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic        iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite;
    logic        ULAsrca;
    logic [1:0]  ULAsrcb;
    logic [2:0]  ULAcontrol;
    logic [1:0]  pcsrc;
    logic        pcen;
    logic [3:0]  state;
    logic [31:0] retired;

    int          compared   = 0;
    int          mismatched = 0;
    logic [31:0] exp_retired;
    int          exp_seq[$];

    typedef struct packed {
        logic       iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite, srca;
        logic [1:0] srcb;
        logic       alu_valid;
        logic [2:0] alu;
        logic [1:0] pcsrc;
        logic       pcen;
    } exp_t;

    mips_multicycle_controller #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .iord(iord), .memread(memread), .memwrite(memwrite), .irwrite(irwrite),
        .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
        .ULAsrca(ULAsrca), .ULAsrcb(ULAsrcb), .ULAcontrol(ULAcontrol),
        .pcsrc(pcsrc), .pcen(pcen), .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    function automatic logic [2:0] funct_alu(input logic [5:0] f);
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // Control-output table per state; ULA operation only checked where defined.
    function automatic exp_t expect_for(input int st, input logic [5:0] f,
                                        input logic z, input logic rst);
        exp_t e = '0;
        case (st)
            0:  begin e.memread = 1; e.irwrite = 1; e.pcen = 1; e.srcb = 2'b01;
                      e.alu_valid = 1; e.alu = 3'b010; end
            1:  begin e.srcb = 2'b11; e.alu_valid = 1; e.alu = 3'b010; end
            2, 9: begin e.srca = 1; e.srcb = 2'b10; e.alu_valid = 1; e.alu = 3'b010; end
            3:  begin e.iord = 1; e.memread = 1; end
            4:  begin e.memtoreg = 1; e.regwrite = 1; end
            5:  begin e.iord = 1; e.memwrite = 1; end
            6:  begin e.srca = 1; e.alu_valid = 1; e.alu = funct_alu(f); end
            7:  begin e.regdst = 1; e.regwrite = 1; end
            8:  begin e.srca = 1; e.alu_valid = 1; e.alu = 3'b110; e.pcsrc = 2'b01;
                      e.pcen = z; end
            10: e.regwrite = 1;
            11: begin e.pcsrc = 2'b10; e.pcen = 1; end
            default: e = '0;
        endcase
        if (rst) begin
            e.memread = 0; e.memwrite = 0; e.irwrite = 0; e.regwrite = 0; e.pcen = 0;
        end
        return e;
    endfunction

    // Visited states for one instruction, starting at FETCH.
    task automatic build_seq(input logic [5:0] o);
        exp_seq = {0, 1};
        case (o)
            6'b100011: exp_seq = {0, 1, 2, 3, 4};
            6'b101011: exp_seq = {0, 1, 2, 5};
            6'b000000: exp_seq = {0, 1, 6, 7};
            6'b000100: exp_seq = {0, 1, 8};
            6'b001000: exp_seq = {0, 1, 9, 10};
            6'b000010: exp_seq = {0, 1, 11};
            default:   exp_seq = {0, 1};
        endcase
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic check_all(input string tag, input int st, input logic rst);
        exp_t e = expect_for(st, funct, zero, rst);
        checkOutput({tag, ".state"},    32'(state),    32'(st));
        checkOutput({tag, ".iord"},     32'(iord),     32'(e.iord));
        checkOutput({tag, ".memread"},  32'(memread),  32'(e.memread));
        checkOutput({tag, ".memwrite"}, 32'(memwrite), 32'(e.memwrite));
        checkOutput({tag, ".irwrite"},  32'(irwrite),  32'(e.irwrite));
        checkOutput({tag, ".regdst"},   32'(regdst),   32'(e.regdst));
        checkOutput({tag, ".memtoreg"}, 32'(memtoreg), 32'(e.memtoreg));
        checkOutput({tag, ".regwrite"}, 32'(regwrite), 32'(e.regwrite));
        checkOutput({tag, ".srca"},     32'(ULAsrca),  32'(e.srca));
        checkOutput({tag, ".srcb"},     32'(ULAsrcb),  32'(e.srcb));
        checkOutput({tag, ".pcsrc"},    32'(pcsrc),    32'(e.pcsrc));
        checkOutput({tag, ".pcen"},     32'(pcen),     32'(e.pcen));
        if (e.alu_valid)
            checkOutput({tag, ".ulactl"}, 32'(ULAcontrol), 32'(e.alu));
    endtask

    // Runs one instruction from FETCH back to FETCH, checking every cycle.
    task automatic applyStimulus(input string tag, input logic [5:0] o,
                                 input logic [5:0] f, input bit rand_zero,
                                 input logic z);
        op    = o;
        funct = f;
        zero  = z;
        build_seq(o);
        foreach (exp_seq[k]) begin
            if (rand_zero) zero = 1'($urandom);
            #1;
            check_all($sformatf("%s.c%0d", tag, k), exp_seq[k], 1'b0);
            if (exp_seq[k] == 8) begin
                zero = ~zero;
                #1;
                checkOutput({tag, ".beq_toggle_pcen"}, 32'(pcen), 32'(zero));
            end
            @(negedge clk);
        end
        exp_retired = exp_retired + 1;
        #1;
        checkOutput({tag, ".end_state"}, 32'(state), 32'd0);
        checkOutput({tag, ".retired"}, retired, exp_retired);
    endtask

    initial begin
        logic [5:0] ops[8];
        logic [5:0] functs[6];

        reset = 1'b1;
        op    = 6'd0;
        funct = 6'd0;
        zero  = 1'b0;
        exp_retired = 32'd0;

        // Two reset cycles, then release and observe FETCH before the next edge.
        @(posedge clk);
        @(negedge clk);
        check_all("rst1", 0, 1'b1);
        checkOutput("rst1.retired", retired, 32'd0);
        @(negedge clk);
        check_all("rst2", 0, 1'b1);
        checkOutput("rst2.retired", retired, 32'd0);
        reset = 1'b0;
        #1;
        check_all("fetch_after_reset", 0, 1'b0);

        $display("[TB] directed instructions");
        applyStimulus("lw",       6'b100011, 6'b000000, 1'b0, 1'b0);
        applyStimulus("r_sub",    6'b000000, 6'b100010, 1'b0, 1'b0);
        applyStimulus("r_slt",    6'b000000, 6'b101010, 1'b0, 1'b0);
        applyStimulus("r_unk",    6'b000000, 6'b111111, 1'b0, 1'b0);
        applyStimulus("beq_z0",   6'b000100, 6'b000000, 1'b0, 1'b0);
        applyStimulus("beq_z1",   6'b000100, 6'b000000, 1'b0, 1'b1);
        applyStimulus("sw",       6'b101011, 6'b000000, 1'b0, 1'b0);
        applyStimulus("j",        6'b000010, 6'b000000, 1'b0, 1'b0);
        applyStimulus("nop",      6'b111111, 6'b000000, 1'b0, 1'b0);
        applyStimulus("addi",     6'b001000, 6'b000000, 1'b0, 1'b0);

        // Reset in the middle of a lw, while in MEMRD.
        $display("[TB] reset during MEMRD");
        op = 6'b100011;
        for (int k = 0; k < 3; k++) begin
            #1;
            check_all($sformatf("midrst.c%0d", k), k, 1'b0);
            @(negedge clk);
        end
        reset = 1'b1;
        #1;
        check_all("midrst.memrd", 3, 1'b1);
        @(negedge clk);
        exp_retired = 32'd0;
        #1;
        check_all("midrst.after", 0, 1'b1);
        checkOutput("midrst.retired", retired, 32'd0);
        reset = 1'b0;
        #1;
        applyStimulus("lw_after_rst", 6'b100011, 6'b000000, 1'b0, 1'b0);

        // Randomized instruction mix with zero changing every cycle.
        $display("[TB] random instructions");
        ops    = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                   6'b001000, 6'b000010, 6'b111111, 6'b000000};
        functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000};
        for (int n = 0; n < 60; n++) begin
            logic [5:0] o;
            logic [5:0] f;
            o = ops[$urandom_range(0, 7)];
            if ($urandom_range(0, 7) == 0) o = 6'($urandom_range(0, 63));
            f = functs[$urandom_range(0, 5)];
            if (f == 6'b000000) f = 6'($urandom_range(0, 63));
            applyStimulus($sformatf("rnd%0d", n), o, f, 1'b1, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
